// File: rtl/oled_task_mux_pkg.sv
// oled_task_mux_pkg: shared FSM states, RGB565 field bounds, black pixel and 7-seg hex table
package oled_task_mux_pkg;

    typedef enum logic [1:0] {MENU, ENTER_BLK, RUN, EXIT_BLK} state_t;

    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    localparam logic [15:0] COLOR_BLACK = 16'h0000;

    // active-low gfedcba segments, index 0..F
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // halve each RGB565 field independently so no bit bleeds into a neighbour field
    function automatic logic [15:0] dim565(input logic [15:0] p);
        return {1'b0, p[R_HI:R_LO+1], 1'b0, p[G_HI:G_LO+1], 1'b0, p[B_HI:B_LO+1]};
    endfunction

endpackage

// File: rtl/oled_task_mux_btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus stable-high counter, one press pulse per hold
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] TOP = CW'(DEBOUNCE_CYCLES);

    logic [1:0] sync;
    logic [CW-1:0] cnt;

    // counter saturates at TOP so a held button never re-fires
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sync  <= '0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn_in};
            cnt   <= !sync[1] ? '0 : cnt == TOP ? cnt : cnt + 1'b1;
            press <= sync[1] && cnt == LAST;
        end

endmodule

// File: rtl/oled_task_mux.sv
// oled_task_mux: menu-driven selector of task pixel sources with blank frames around switches; OLED_TASK_MUX_SEG_EN shows the task digit on the 7-seg
module oled_task_mux
    import oled_task_mux_pkg::*;
#(
    parameter int NUM_TASKS       = 4,
    parameter int PIX_W           = 16,
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int BLANK_FRAMES    = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         btn_next,
    input  logic                         btn_prev,
    input  logic                         btn_sel,
    input  logic [SW_W-1:0]              sw,
    input  logic                         frame_begin,
    input  logic [NUM_TASKS*PIX_W-1:0]   task_pixel,
    output logic [PIX_W-1:0]             pixel_data,
    output logic [NUM_TASKS-1:0]         task_run,
    output logic [$clog2(NUM_TASKS)-1:0] cursor,
    output logic                         reject,
    output logic [7:0]                   seg,
    output logic [3:0]                   an
);

    localparam int CW = $clog2(NUM_TASKS);
    localparam int FW = $clog2(BLANK_FRAMES + 1);
    localparam logic [CW-1:0] CUR_LAST = CW'(NUM_TASKS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLANK_FRAMES - 1);

    state_t state;
    logic [FW-1:0] fcnt;
    logic p_next, p_prev, p_sel, last_frame;
    logic [PIX_W-1:0] sel_pix;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (.clk(clk), .reset_n(reset_n), .btn_in(btn_next), .press(p_next));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (.clk(clk), .reset_n(reset_n), .btn_in(btn_prev), .press(p_prev));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel  (.clk(clk), .reset_n(reset_n), .btn_in(btn_sel),  .press(p_sel));

    assign last_frame = frame_begin && fcnt == FRM_LAST;

    // cursor task source; out-of-range cursor values fall back to zero
    always_comb begin
        sel_pix = '0;
        for (int k = 0; k < NUM_TASKS; k++)
            if (cursor == CW'(k)) sel_pix = task_pixel[k*PIX_W +: PIX_W];
    end

    // menu/blank/run sequencing; the frame counter clears on every state entry
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state    <= MENU;
            cursor   <= '0;
            fcnt     <= '0;
            task_run <= '0;
            reject   <= 1'b0;
        end else begin
            reject <= 1'b0;
            case (state)
                MENU:
                    if (p_sel) begin
                        if (sw[cursor]) begin
                            state <= ENTER_BLK;
                            fcnt  <= '0;
                        end else
                            reject <= 1'b1;
                    end else if (p_next && !p_prev)
                        cursor <= cursor == CUR_LAST ? '0 : cursor + 1'b1;
                    else if (p_prev && !p_next)
                        cursor <= cursor == '0 ? CUR_LAST : cursor - 1'b1;
                ENTER_BLK:
                    if (last_frame) begin
                        state    <= RUN;
                        fcnt     <= '0;
                        task_run <= NUM_TASKS'(1) << cursor;
                    end else if (frame_begin)
                        fcnt <= fcnt + 1'b1;
                RUN:
                    if (p_sel || !sw[cursor]) begin
                        state    <= EXIT_BLK;
                        fcnt     <= '0;
                        task_run <= '0;
                    end
                default:
                    if (last_frame) begin
                        state <= MENU;
                        fcnt  <= '0;
                    end else if (frame_begin)
                        fcnt <= fcnt + 1'b1;
            endcase
        end

    // registered pixel: dimmed preview in menu, raw source while running, black while blanked
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            pixel_data <= '0;
        else
            pixel_data <= state == MENU ? PIX_W'(dim565(16'(sel_pix))) :
                          state == RUN  ? sel_pix : PIX_W'(COLOR_BLACK);

`ifdef OLED_TASK_MUX_SEG_EN
    logic [6:0] digit;
    assign digit = SEG_HEX[4'(cursor) + 4'd1];

    // task number (cursor+1) on the rightmost digit; dp lit marks the menu preview
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            seg <= 8'hFF;
            an  <= 4'hF;
        end else begin
            seg <= state == RUN ? {1'b1, digit} : state == MENU ? {1'b0, digit} : 8'hFF;
            an  <= state == RUN || state == MENU ? 4'b1110 : 4'hF;
        end
`else
    assign seg = 8'hFF;
    assign an  = 4'hF;
`endif

endmodule

// File: tb/tb_oled_task_mux.sv
// tb_oled_task_mux: directed vector table, hand sequences and randomized ops against a behavioural model
module tb_oled_task_mux;

    localparam int N = 4, PW = 16, D = 4, BF = 2;

    typedef enum int {OP_NEXT, OP_PREV, OP_BOTH, OP_SEL, OP_FRAME, OP_SW, OP_GLITCH} op_t;
    // mode: 0 menu, 1 entering (blank), 2 running, 3 exiting (blank)
    typedef struct {
        op_t         op;
        logic [15:0] arg;
        int          mode;
        int          c;
        int          rej;
    } vec_t;

    logic clk = 0, reset_n = 0, btn_next = 0, btn_prev = 0, btn_sel = 0, frame_begin = 0;
    logic [15:0] sw = 0;
    logic [N*PW-1:0] task_pixel = 0;
    logic [PW-1:0] pixel_data;
    logic [N-1:0] task_run;
    logic [1:0] cursor;
    logic reject;
    logic [7:0] seg;
    logic [3:0] an;

    int total = 0, bad = 0, rej_seen = 0;
    int m_mode = 0, m_c = 0, m_f = 0;
    logic [15:0] m_sw = 0;
    vec_t tbl[17];
    logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    oled_task_mux #(.NUM_TASKS(N), .PIX_W(PW), .SW_W(16), .DEBOUNCE_CYCLES(D), .BLANK_FRAMES(BF)) dut (
        .clk(clk), .reset_n(reset_n), .btn_next(btn_next), .btn_prev(btn_prev), .btn_sel(btn_sel),
        .sw(sw), .frame_begin(frame_begin), .task_pixel(task_pixel), .pixel_data(pixel_data),
        .task_run(task_run), .cursor(cursor), .reject(reject), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (reject === 1'b1) rej_seen++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic buttons(input logic n, input logic p, input logic s, input int hold);
        tick();
        btn_next = n; btn_prev = p; btn_sel = s;
        repeat (hold) tick();
        btn_next = 0; btn_prev = 0; btn_sel = 0;
        repeat (8) tick();
    endtask

    task automatic frame();
        tick();
        frame_begin = 1;
        tick();
        frame_begin = 0;
        repeat (3) tick();
    endtask

    task automatic do_op(input op_t op, input logic [15:0] arg);
        case (op)
            OP_NEXT:   buttons(1, 0, 0, 8);
            OP_PREV:   buttons(0, 1, 0, 8);
            OP_BOTH:   buttons(1, 1, 0, 8);
            OP_SEL:    buttons(0, 0, 1, 8);
            OP_GLITCH: buttons(1, 0, 0, 3);
            OP_FRAME:  frame();
            default: begin sw = arg; repeat (3) tick(); end
        endcase
    endtask

    function automatic logic [15:0] dim(input logic [15:0] p);
        int v = int'(p);
        return 16'(((v / 2048) / 2) * 2048 + (((v / 32) % 64) / 2) * 32 + (v % 32) / 2);
    endfunction

    function automatic logic [15:0] exp_pix(input int mode, input int c);
        logic [15:0] p = task_pixel[c*16 +: 16];
        return mode == 0 ? dim(p) : mode == 2 ? p : 16'h0000;
    endfunction

    function automatic logic [7:0] exp_seg(input int mode, input int c);
`ifdef OLED_TASK_MUX_SEG_EN
        return mode == 2 ? {1'b1, hex7[c + 1]} : mode == 0 ? {1'b0, hex7[c + 1]} : 8'hFF;
`else
        return 8'hFF;
`endif
    endfunction

    function automatic logic [3:0] exp_an(input int mode);
`ifdef OLED_TASK_MUX_SEG_EN
        return (mode == 0 || mode == 2) ? 4'b1110 : 4'hF;
`else
        return 4'hF;
`endif
    endfunction

    task automatic check_all(input string nm, input int mode, input int c, input int rej, input int r0);
        @(negedge clk);
        chk({nm, " cursor"}, 64'(cursor), 64'(c));
        chk({nm, " task_run"}, 64'(task_run), mode == 2 ? 64'(1) << c : 64'(0));
        chk({nm, " reject"}, 64'(rej_seen - r0), 64'(rej));
        tick();
        task_pixel = {$urandom, $urandom};
        repeat (2) tick();
        @(negedge clk);
        chk({nm, " pixel"}, 64'(pixel_data), 64'(exp_pix(mode, c)));
        chk({nm, " seg"}, 64'(seg), 64'(exp_seg(mode, c)));
        chk({nm, " an"}, 64'(an), 64'(exp_an(mode)));
    endtask

    // abstract menu model: what each user action does to mode/cursor, returns expected reject pulses
    function automatic int model(input op_t op, input logic [15:0] arg);
        int rej = 0;
        case (op)
            OP_NEXT: if (m_mode == 0) m_c = (m_c + 1) % N;
            OP_PREV: if (m_mode == 0) m_c = (m_c + N - 1) % N;
            OP_SEL:
                if (m_mode == 0) begin
                    if (m_sw[m_c]) begin m_mode = 1; m_f = 0; end
                    else rej = 1;
                end else if (m_mode == 2) begin
                    m_mode = 3; m_f = 0;
                end
            OP_FRAME:
                if (m_mode == 1 || m_mode == 3) begin
                    m_f++;
                    if (m_f == BF) begin m_mode = m_mode == 1 ? 2 : 0; m_f = 0; end
                end
            OP_SW: begin
                m_sw = arg;
                if (m_mode == 2 && !m_sw[m_c]) begin m_mode = 3; m_f = 0; end
            end
            default: ;
        endcase
        return rej;
    endfunction

    initial begin
        int r0, rej;
        op_t op;
        logic [15:0] arg;
        tbl[0]  = '{OP_PREV,   16'h0000, 0, 3, 0};
        tbl[1]  = '{OP_NEXT,   16'h0000, 0, 0, 0};
        tbl[2]  = '{OP_GLITCH, 16'h0000, 0, 0, 0};
        tbl[3]  = '{OP_NEXT,   16'h0000, 0, 1, 0};
        tbl[4]  = '{OP_SEL,    16'h0000, 0, 1, 1};
        tbl[5]  = '{OP_NEXT,   16'h0000, 0, 2, 0};
        tbl[6]  = '{OP_SW,     16'h0004, 0, 2, 0};
        tbl[7]  = '{OP_SEL,    16'h0000, 1, 2, 0};
        tbl[8]  = '{OP_FRAME,  16'h0000, 1, 2, 0};
        tbl[9]  = '{OP_FRAME,  16'h0000, 2, 2, 0};
        tbl[10] = '{OP_NEXT,   16'h0000, 2, 2, 0};
        tbl[11] = '{OP_PREV,   16'h0000, 2, 2, 0};
        tbl[12] = '{OP_SW,     16'h0000, 3, 2, 0};
        tbl[13] = '{OP_FRAME,  16'h0000, 3, 2, 0};
        tbl[14] = '{OP_FRAME,  16'h0000, 0, 2, 0};
        tbl[15] = '{OP_BOTH,   16'h0000, 0, 2, 0};
        tbl[16] = '{OP_SEL,    16'h0000, 0, 2, 1};

        repeat (3) tick();
        chk("reset cursor", 64'(cursor), 0);
        chk("reset task_run", 64'(task_run), 0);
        chk("reset pixel", 64'(pixel_data), 0);
        chk("reset reject", 64'(reject), 0);
        chk("reset seg", 64'(seg), 64'h FF);
        chk("reset an", 64'(an), 64'hF);
        @(negedge clk);
        reset_n = 1;
        repeat (2) tick();

        for (int i = 0; i < 17; i++) begin
            r0 = rej_seen;
            do_op(tbl[i].op, tbl[i].arg);
            check_all($sformatf("vec%0d", i), tbl[i].mode, tbl[i].c, tbl[i].rej, r0);
        end

        tick();
        task_pixel = 64'h0;
        task_pixel[2*16 +: 16] = 16'hF81F;
        repeat (2) tick();
        @(negedge clk);
        chk("dim F81F", 64'(pixel_data), 64'h780F);

        do_op(OP_SW, 16'h0004);
        do_op(OP_SEL, 16'h0);
        do_op(OP_FRAME, 16'h0);
        @(negedge clk);
        chk("entry blank pixel", 64'(pixel_data), 0);
        chk("entry blank run", 64'(task_run), 0);
        do_op(OP_FRAME, 16'h0);
        task_pixel[2*16 +: 16] = 16'hFFFF;
        repeat (2) tick();
        @(negedge clk);
        chk("entry run", 64'(task_run), 64'b0100);
        chk("entry pixel FFFF", 64'(pixel_data), 64'hFFFF);
`ifdef OLED_TASK_MUX_SEG_EN
        chk("run digit seg", 64'(seg), 64'hB0);
        chk("run digit an", 64'(an), 64'hE);
`endif

        @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("async reset task_run", 64'(task_run), 0);
        chk("async reset cursor", 64'(cursor), 0);
        chk("async reset pixel", 64'(pixel_data), 0);
        @(negedge clk);
        reset_n = 1;
        sw = 0;
        repeat (3) tick();

        m_mode = 0; m_c = 0; m_f = 0; m_sw = 0;
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    op = OP_NEXT;
                2, 3:    op = OP_PREV;
                4:       op = OP_BOTH;
                5, 6:    op = OP_SEL;
                7, 8:    op = OP_FRAME;
                default: op = OP_SW;
            endcase
            if (op == OP_SW && (m_mode == 1 || m_mode == 3)) op = OP_FRAME;
            arg = 16'($urandom);
            r0 = rej_seen;
            rej = model(op, arg);
            do_op(op, arg);
            check_all($sformatf("rnd%0d op%0d", i, op), m_mode, m_c, rej, r0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
